// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction memory request, maintains the PC
// and the IF/ID pipeline register, with a one-entry skid buffer and post-flush drain.
module fetch_stage (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ready_i,
   input  logic [31:0] imem_data_i,
   output logic [31:0] fetch_pc_o,
   output logic [31:0] ifid_pc4_o,
   output logic [31:0] ifid_instr_o,
   output logic        ifid_valid_o
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

   state_t      state_reg;
   logic [31:0] pc_reg;
   logic        req_reg;
   logic [31:0] addr_reg;
   logic [31:0] ifid_pc4_reg;
   logic [31:0] ifid_instr_reg;
   logic        ifid_valid_reg;
   logic [31:0] skid_instr_reg;
   logic [31:0] skid_pc4_reg;
   logic [31:0] drain_addr_reg;

   logic [31:0] pc_plus4;
   logic [31:0] target_aligned;

   assign pc_plus4       = pc_reg + 32'd4;
   assign target_aligned = {target_i[31:2], 2'b00};

   // In FETCH the request address always mirrors the PC; in DRAIN it is the
   // pre-flush address that memory still owes us a response for.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg      <= IDLE;
         pc_reg         <= 32'd0;
         req_reg        <= 1'b0;
         addr_reg       <= 32'd0;
         ifid_pc4_reg   <= 32'd0;
         ifid_instr_reg <= 32'd0;
         ifid_valid_reg <= 1'b0;
         skid_instr_reg <= 32'd0;
         skid_pc4_reg   <= 32'd0;
         drain_addr_reg <= 32'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               state_reg <= FETCH;
               req_reg   <= 1'b1;
               addr_reg  <= pc_reg;
            end
            FETCH: begin
               if (stall_i) begin
                  if (imem_ready_i) begin
                     skid_instr_reg <= imem_data_i;
                     skid_pc4_reg   <= pc_plus4;
                     req_reg        <= 1'b0;
                     state_reg      <= HOLD;
                  end
               end else if (flush_i) begin
                  ifid_pc4_reg   <= 32'd0;
                  ifid_instr_reg <= 32'd0;
                  ifid_valid_reg <= 1'b0;
                  pc_reg         <= target_aligned;
                  if (imem_ready_i) begin
                     addr_reg <= target_aligned;
                  end else begin
                     drain_addr_reg <= pc_reg;
                     state_reg      <= DRAIN;
                  end
               end else if (imem_ready_i) begin
                  ifid_pc4_reg   <= pc_plus4;
                  ifid_instr_reg <= imem_data_i;
                  ifid_valid_reg <= 1'b1;
                  pc_reg         <= pc_plus4;
                  addr_reg       <= pc_plus4;
               end else begin
                  ifid_pc4_reg   <= 32'd0;
                  ifid_instr_reg <= 32'd0;
                  ifid_valid_reg <= 1'b0;
               end
            end
            HOLD: begin
               if (!stall_i) begin
                  state_reg <= FETCH;
                  req_reg   <= 1'b1;
                  if (flush_i) begin
                     ifid_pc4_reg   <= 32'd0;
                     ifid_instr_reg <= 32'd0;
                     ifid_valid_reg <= 1'b0;
                     pc_reg         <= target_aligned;
                     addr_reg       <= target_aligned;
                     skid_instr_reg <= 32'd0;
                     skid_pc4_reg   <= 32'd0;
                  end else begin
                     ifid_pc4_reg   <= skid_pc4_reg;
                     ifid_instr_reg <= skid_instr_reg;
                     ifid_valid_reg <= 1'b1;
                     pc_reg         <= pc_plus4;
                     addr_reg       <= pc_plus4;
                  end
               end
            end
            DRAIN: begin
               if (!stall_i) begin
                  ifid_pc4_reg   <= 32'd0;
                  ifid_instr_reg <= 32'd0;
                  ifid_valid_reg <= 1'b0;
                  if (flush_i) pc_reg <= target_aligned;
               end
               // The owed response is dropped; resume at the latest target.
               if (imem_ready_i) begin
                  state_reg <= FETCH;
                  addr_reg  <= (!stall_i && flush_i) ? target_aligned : pc_reg;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign imem_req_o   = req_reg;
   assign imem_addr_o  = (state_reg == DRAIN) ? drain_addr_reg : addr_reg;
   assign fetch_pc_o   = pc_reg;
   assign ifid_pc4_o   = ifid_pc4_reg;
   assign ifid_instr_o = ifid_instr_reg;
   assign ifid_valid_o = ifid_valid_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes hand-computed post-edge
// snapshots into a queue, a monitor pops and compares them on the falling edge.
module tb_fetch_stage;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        stall_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [31:0] target_i = 32'd0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ready_i = 1'b0;
   logic [31:0] imem_data_i = 32'd0;
   logic [31:0] fetch_pc_o;
   logic [31:0] ifid_pc4_o;
   logic [31:0] ifid_instr_o;
   logic        ifid_valid_o;

   fetch_stage dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .stall_i      (stall_i),
      .flush_i      (flush_i),
      .target_i     (target_i),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_ready_i (imem_ready_i),
      .imem_data_i  (imem_data_i),
      .fetch_pc_o   (fetch_pc_o),
      .ifid_pc4_o   (ifid_pc4_o),
      .ifid_instr_o (ifid_instr_o),
      .ifid_valid_o (ifid_valid_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] instr;
      logic        valid;
   } snap_t;

   typedef struct {
      int    id;
      snap_t s;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   vec_id = 0;

   task automatic cmp(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s vec %0d: got %h expected %h", name, id, act, req);
      end
   endtask

   task automatic check_snap(input int id, input snap_t e);
      cmp("imem_req",   id, {31'd0, imem_req_o},   {31'd0, e.req});
      cmp("imem_addr",  id, imem_addr_o,             e.addr);
      cmp("fetch_pc",   id, fetch_pc_o,              e.pc);
      cmp("ifid_pc4",   id, ifid_pc4_o,              e.pc4);
      cmp("ifid_instr", id, ifid_instr_o,            e.instr);
      cmp("ifid_valid", id, {31'd0, ifid_valid_o},   {31'd0, e.valid});
      $display("vec %0d: req=%b addr=%h pc=%h pc4=%h instr=%h valid=%b", id,
               imem_req_o, imem_addr_o, fetch_pc_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o);
   endtask

   // Monitor: one expected snapshot per clock edge issued by the stimulus.
   initial begin
      forever begin
         @(negedge clk_i);
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_snap(e.id, e.s);
         end
      end
   end

   // Apply one cycle of inputs; expected values describe the state after the edge.
   task automatic step(input logic st, input logic fl, input logic [31:0] tgt,
                       input logic rdy, input logic [31:0] data,
                       input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_pc,
                       input logic [31:0] e_pc4, input logic [31:0] e_instr, input logic e_valid);
      exp_t e;
      stall_i      = st;
      flush_i      = fl;
      target_i     = tgt;
      imem_ready_i = rdy;
      imem_data_i  = data;
      e.id = vec_id;
      e.s  = '{req: e_req, addr: e_addr, pc: e_pc, pc4: e_pc4, instr: e_instr, valid: e_valid};
      exp_q.push_back(e);
      vec_id++;
      @(posedge clk_i);
      @(negedge clk_i);
      #1;
   endtask

   task automatic check_zero(input string tag);
      snap_t z;
      z = '0;
      $display("%s: checking all-zero outputs", tag);
      check_snap(vec_id, z);
      vec_id++;
   endtask

   initial begin
      @(negedge clk_i);
      #1;
      check_zero("reset");
      rst_i = 1'b0;
      //   st fl  tgt            rdy data           req addr           pc             pc4            instr          v
      step(0, 0, 32'h0,          0, 32'h0,          1, 32'h0,          32'h0,         32'h0,         32'h0,         0); // IDLE -> FETCH
      step(0, 0, 32'h0,          1, 32'h11,         1, 32'h4,          32'h4,         32'h4,         32'h11,        1);
      step(0, 0, 32'h0,          1, 32'h22,         1, 32'h8,          32'h8,         32'h8,         32'h22,        1);
      step(0, 0, 32'h0,          1, 32'h33,         1, 32'hC,          32'hC,         32'hC,         32'h33,        1);
      step(1, 0, 32'h0,          1, 32'h44,         0, 32'hC,          32'hC,         32'hC,         32'h33,        1); // -> HOLD
      step(1, 1, 32'h500,        0, 32'h0,          0, 32'hC,          32'hC,         32'hC,         32'h33,        1); // flush ignored
      step(0, 0, 32'h0,          0, 32'h0,          1, 32'h10,         32'h10,        32'h10,        32'h44,        1); // release skid
      step(1, 1, 32'h300,        0, 32'h0,          1, 32'h10,         32'h10,        32'h10,        32'h44,        1); // stall+flush
      step(0, 0, 32'h0,          0, 32'h0,          1, 32'h10,         32'h10,        32'h0,         32'h0,         0); // wait bubble
      step(0, 1, 32'h100,        1, 32'hDEAD,       1, 32'h100,        32'h100,       32'h0,         32'h0,         0); // flush w/ ready
      step(0, 0, 32'h0,          1, 32'h55,         1, 32'h104,        32'h104,       32'h104,       32'h55,        1);
      step(0, 1, 32'h202,        0, 32'h0,          1, 32'h104,        32'h200,       32'h0,         32'h0,         0); // -> DRAIN
      step(0, 0, 32'h0,          0, 32'h0,          1, 32'h104,        32'h200,       32'h0,         32'h0,         0);
      step(0, 0, 32'h0,          0, 32'h0,          1, 32'h104,        32'h200,       32'h0,         32'h0,         0);
      step(0, 0, 32'h0,          1, 32'h66,         1, 32'h200,        32'h200,       32'h0,         32'h0,         0); // dropped
      step(0, 0, 32'h0,          1, 32'h77,         1, 32'h204,        32'h204,       32'h204,       32'h77,        1);
      step(0, 1, 32'h400,        0, 32'h0,          1, 32'h204,        32'h400,       32'h0,         32'h0,         0); // -> DRAIN
      step(0, 1, 32'h600,        0, 32'h0,          1, 32'h204,        32'h600,       32'h0,         32'h0,         0); // retarget
      step(0, 0, 32'h0,          1, 32'h0,          1, 32'h600,        32'h600,       32'h0,         32'h0,         0);
      step(0, 0, 32'h0,          1, 32'h88,         1, 32'h604,        32'h604,       32'h604,       32'h88,        1);
      step(1, 0, 32'h0,          1, 32'h99,         0, 32'h604,        32'h604,       32'h604,       32'h88,        1); // -> HOLD
      step(0, 1, 32'hFFFFFFFC,   0, 32'h0,          1, 32'hFFFFFFFC,   32'hFFFFFFFC,  32'h0,         32'h0,         0); // skid dropped
      step(0, 0, 32'h0,          1, 32'hAA,         1, 32'h0,          32'h0,         32'h0,         32'hAA,        1); // PC wraps
      step(0, 0, 32'h0,          1, 32'hBB,         1, 32'h4,          32'h4,         32'h4,         32'hBB,        1);
      step(0, 1, 32'h700,        0, 32'h0,          1, 32'h4,          32'h700,       32'h0,         32'h0,         0); // -> DRAIN
      rst_i = 1'b1;
      #1;
      check_zero("async reset mid-DRAIN");
      imem_ready_i = 1'b1;
      imem_data_i  = 32'hCC;
      @(posedge clk_i);
      @(negedge clk_i);
      #1;
      rst_i = 1'b0;
      step(0, 0, 32'h0,          1, 32'hCC,         1, 32'h0,          32'h0,         32'h0,         32'h0,         0); // IDLE ignores ready
      step(0, 0, 32'h0,          1, 32'hDD,         1, 32'h4,          32'h4,         32'h4,         32'hDD,        1);
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk_i);
      if (exp_q.size() > 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain_queue: %0d snapshots left unchecked, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with the ports listed below.
REQ-002 The block SHALL have these ports, one per line as: name, direction, width, meaning.
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous active-high reset.
- stall_i  input  1  load-use stall from the hazard detection unit; 1 = hold PC and IF/ID.
- flush_i  input  1  branch/jump taken in ID; squash IF/ID and redirect the PC.
- target_i  input  32  redirect address, valid when flush_i=1.
- imem_req_o  output  1  instruction memory request.
- imem_addr_o  output  32  request address (word aligned).
- imem_ready_i  input  1  memory response; imem_data_i is valid this cycle.
- imem_data_i  input  32  fetched instruction.
- fetch_pc_o  output  32  current fetch PC.
- ifid_pc4_o  output  32  IF/ID register: PC+4 of the held instruction.
- ifid_instr_o  output  32  IF/ID register: instruction (0x00000000 = nop bubble).
- ifid_valid_o  output  1  IF/ID register: 1 = real instruction, 0 = bubble.

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, FETCH, HOLD, DRAIN.
REQ-004 IDLE: imem_req_o=0; unconditional transition to FETCH on the next edge.
REQ-005 FETCH: imem_req_o=1 and imem_addr_o=PC.
- The address SHALL remain constant until imem_ready_i=1.
- The request SHALL NOT be withdrawn or re-addressed before imem_ready_i=1, even on flush.
REQ-006 FETCH, imem_ready_i=1, stall_i=0, flush_i=0:
- IF/ID <= {PC+4, imem_data_i, valid=1}.
- PC <= PC+4.
- Stay in FETCH, so back-to-back fetches are possible with 1-cycle memory.
REQ-007 FETCH, imem_ready_i=1, stall_i=1:
- Capture imem_data_i and PC+4 in a one-entry skid buffer.
- IF/ID and PC hold.
- Go to HOLD.
REQ-008 HOLD: imem_req_o=0.
- While stall_i=1, remain in HOLD; IF/ID and the buffer hold.
- When stall_i=0 and flush_i=0: IF/ID <= buffer (valid=1), PC <= PC+4, go to FETCH.
- When stall_i=0 and flush_i=1: discard the buffer, IF/ID <= bubble, PC <= target_i, go to FETCH.
REQ-009 FETCH, imem_ready_i=0, stall_i=0, flush_i=0:
- IF/ID <= bubble (instr=0, valid=0, pc4=0).
- PC holds.
REQ-010 FETCH, stall_i=1, imem_ready_i=0: IF/ID and PC SHALL hold unchanged.
REQ-011 Flush with stall_i=0:
- IF/ID <= bubble in that cycle.
- PC <= target_i.
- If imem_ready_i=1 in the same cycle, the response SHALL be discarded and the state SHALL remain FETCH at target_i.
- If imem_ready_i=0, the state SHALL go to DRAIN.
REQ-012 DRAIN:
- Keep imem_req_o=1 with the old, pre-flush address, held in an internal register.
- The response SHALL be discarded when imem_ready_i=1.
- The state then goes to FETCH with PC = the captured target.
- IF/ID SHALL be a bubble every DRAIN cycle in which stall_i=0.
REQ-013 A flush_i arriving in DRAIN SHALL overwrite the pending target.
REQ-014 stall_i SHALL take priority over flush_i: flush_i is ignored while stall_i=1.
REQ-015 PC arithmetic SHALL be 32-bit unsigned modulo 2^32, so 0xFFFFFFFC+4 wraps to 0x00000000.
REQ-016 target_i[1:0] SHALL be forced to 00 when loaded into the PC.
REQ-017 fetch_pc_o SHALL always equal the internal PC register.

Reset
REQ-018 While rst_i=1, asynchronously:
- state=IDLE, PC=0x00000000.
- imem_req_o=0, imem_addr_o=0.
- ifid_pc4_o=0, ifid_instr_o=0, ifid_valid_o=0.
- Skid buffer and pending target cleared.
REQ-019 Reset asserted mid-transaction, in FETCH, HOLD or DRAIN, SHALL abandon the transaction; no response after reset deassertion SHALL be captured unless requested after IDLE.

Verification
REQ-020 Streaming: reset, then imem_ready_i=1 every cycle with data 0x11,0x22,0x33 -> ifid_instr_o is 0x11,0x22,0x33 on consecutive cycles, with ifid_pc4_o 4,8,12 and valid=1.
REQ-021 Load-use stall: stall_i=1 for 2 cycles while the word at 0x8 (0x33) returns -> IF/ID holds 0x22/pc4 8 during the stall, then becomes 0x33/pc4 12; imem_req_o=0 during HOLD.
REQ-022 Flush with ready: flush_i=1, target_i=0x100, imem_ready_i=1 -> IF/ID bubble, next imem_addr_o=0x100, response discarded.
REQ-023 Flush during a wait: flush_i=1, target_i=0x200, imem_ready_i=0 for 3 cycles -> imem_addr_o keeps the old address until ready, then becomes 0x200; IF/ID shows bubbles throughout.
REQ-024 Stall and flush together: stall_i=1 and flush_i=1 -> PC and IF/ID unchanged; the flush has no effect.
REQ-025 PC wrap and mid-fetch reset: PC forced to 0xFFFFFFFC with ready=1 -> next PC is 0x0; rst_i pulsed mid-DRAIN -> all outputs 0 immediately, IDLE, then FETCH at 0x0.
